lfsr_period_gen: RTL and testbench

//  Parametrised Galois LFSR pseudo-random generator with seed load and zero-seed protection.

---
 rtl/lfsr_period_gen.sv | 108 ++++++++++
 tb/tb_lfsr_period_gen.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_period_gen.sv
// Galois LFSR with guarded seed load and an in-RTL period monitor that counts
// advances until the state returns to a captured reference (or times out).
module lfsr_period_gen #(
  parameter int unsigned      WIDTH        = 8,
  parameter logic [WIDTH-1:0] TAPS         = 8'hB8,
  parameter logic [WIDTH-1:0] DEFAULT_SEED = 8'h01
) (
  input  logic             clk,
  input  logic             i_rst,
  input  logic             i_valid,
  input  logic             i_soft_reset,
  input  logic [WIDTH-1:0] i_seed,
  input  logic             i_measure,
  output logic [WIDTH-1:0] o_lfsr,
  output logic             o_seed_err,
  output logic             o_busy,
  output logic [WIDTH:0]   o_period,
  output logic             o_period_valid,
  output logic             o_period_timeout
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_DONE    = 2'd2
  } state_e;

  // Last count value before the 2**WIDTH bound; cnt never wraps past it.
  localparam logic [WIDTH:0] CNT_LAST = {1'b0, {WIDTH{1'b1}}};
  localparam logic [WIDTH:0] CNT_ONE  = {{WIDTH{1'b0}}, 1'b1};

  state_e           state_q;
  logic [WIDTH-1:0] lfsr_q, lfsr_d;
  logic [WIDTH-1:0] ref_q;
  logic [WIDTH-1:0] seed_d;
  logic [WIDTH:0]   cnt_q;
  logic [WIDTH:0]   period_q;
  logic             seed_err_q, period_valid_q, timeout_q, busy_q;
  logic             start, advance, hit_ref, cnt_last;

  always_comb begin
    lfsr_d = {1'b0, lfsr_q[WIDTH-1:1]};
    if (lfsr_q[0]) lfsr_d = lfsr_d ^ TAPS;
  end

  assign seed_d   = (i_seed == '0) ? DEFAULT_SEED : i_seed;
  assign start    = i_soft_reset | i_measure;
  // A start cycle swallows i_valid: no advance and no count.
  assign advance  = i_valid & ~start;
  assign hit_ref  = (lfsr_d == ref_q);
  assign cnt_last = (cnt_q == CNT_LAST);

  always_ff @(posedge clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q        <= ST_IDLE;
      lfsr_q         <= DEFAULT_SEED;
      ref_q          <= DEFAULT_SEED;
      cnt_q          <= '0;
      period_q       <= '0;
      seed_err_q     <= 1'b0;
      period_valid_q <= 1'b0;
      timeout_q      <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      seed_err_q     <= 1'b0;
      period_valid_q <= 1'b0;
      if (i_soft_reset) begin
        lfsr_q     <= seed_d;
        ref_q      <= seed_d;
        cnt_q      <= '0;
        timeout_q  <= 1'b0;
        seed_err_q <= (i_seed == '0);
        state_q    <= ST_MEASURE;
        busy_q     <= 1'b1;
      end else if (i_measure) begin
        ref_q     <= lfsr_q;
        cnt_q     <= '0;
        timeout_q <= 1'b0;
        state_q   <= ST_MEASURE;
        busy_q    <= 1'b1;
      end else if (advance) begin
        lfsr_q <= lfsr_d;
        if (state_q == ST_MEASURE) begin
          if (hit_ref) begin
            period_q       <= cnt_q + CNT_ONE;
            period_valid_q <= 1'b1;
            state_q        <= ST_DONE;
            busy_q         <= 1'b0;
          end else if (cnt_last) begin
            timeout_q <= 1'b1;
            state_q   <= ST_DONE;
            busy_q    <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
      end
    end
  end

  assign o_lfsr           = lfsr_q;
  assign o_seed_err       = seed_err_q;
  assign o_busy           = busy_q;
  assign o_period         = period_q;
  assign o_period_valid   = period_valid_q;
  assign o_period_timeout = timeout_q;

endmodule

// File: tb/tb_lfsr_period_gen.sv
// Bench for lfsr_period_gen: 8-bit default instance plus two 4-bit instances
// (maximal-ish TAPS=F loop and non-returning TAPS=3 tail).
module tb_lfsr_period_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic       v8, sr8, ms8;
  logic [7:0] seed8, lf8;
  logic       se8, bz8, pv8, to8;
  logic [8:0] per8;

  logic       a_v, a_sr, a_ms, a_se, a_bz, a_pv, a_to;
  logic [3:0] a_seed, a_lf;
  logic [4:0] a_per;

  logic       b_v, b_sr, b_ms, b_se, b_bz, b_pv, b_to;
  logic [3:0] b_seed, b_lf;
  logic [4:0] b_per;

  lfsr_period_gen u8 (
    .clk(clk), .i_rst(rst_n), .i_valid(v8), .i_soft_reset(sr8), .i_seed(seed8),
    .i_measure(ms8), .o_lfsr(lf8), .o_seed_err(se8), .o_busy(bz8), .o_period(per8),
    .o_period_valid(pv8), .o_period_timeout(to8));

  lfsr_period_gen #(.WIDTH(4), .TAPS(4'hF), .DEFAULT_SEED(4'h1)) u4a (
    .clk(clk), .i_rst(rst_n), .i_valid(a_v), .i_soft_reset(a_sr), .i_seed(a_seed),
    .i_measure(a_ms), .o_lfsr(a_lf), .o_seed_err(a_se), .o_busy(a_bz), .o_period(a_per),
    .o_period_valid(a_pv), .o_period_timeout(a_to));

  lfsr_period_gen #(.WIDTH(4), .TAPS(4'h3), .DEFAULT_SEED(4'h1)) u4b (
    .clk(clk), .i_rst(rst_n), .i_valid(b_v), .i_soft_reset(b_sr), .i_seed(b_seed),
    .i_measure(b_ms), .o_lfsr(b_lf), .o_seed_err(b_se), .o_busy(b_bz), .o_period(b_per),
    .o_period_valid(b_pv), .o_period_timeout(b_to));

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] nxt8(input logic [7:0] s);
    return (s >> 1) ^ (s[0] ? 8'hB8 : 8'h00);
  endfunction

  typedef struct {
    int         sel;
    logic       sr, ms, vl;
    logic [3:0] seed;
    logic [3:0] lf;
    logic       bz, pv;
    logic [4:0] per;
    logic       to, se;
  } vec_t;

  function automatic vec_t mk(int sel, logic sr, logic ms, logic vl, logic [3:0] seed,
                              logic [3:0] lf, logic bz, logic pv, logic [4:0] per,
                              logic to, logic se);
    vec_t v;
    v.sel = sel; v.sr = sr; v.ms = ms; v.vl = vl; v.seed = seed;
    v.lf = lf; v.bz = bz; v.pv = pv; v.per = per; v.to = to; v.se = se;
    return v;
  endfunction

  vec_t tv[$];
  logic [3:0] seq4b [16];

  int         pv_at, npv, bad;
  logic [7:0] m, lf_at, cap;
  logic [8:0] per_at;
  logic [3:0] o_lf;
  logic       o_bz, o_pv, o_to, o_se;
  logic [4:0] o_per;

  initial begin
    rst_n = 1'b0;
    {v8, sr8, ms8} = '0; seed8 = '0;
    {a_v, a_sr, a_ms} = '0; a_seed = '0;
    {b_v, b_sr, b_ms} = '0; b_seed = '0;

    // ---- 4-bit vector table ----
    // TAPS=F, seed 1: 1,F,8,4,2,1 -> period 5
    tv.push_back(mk(0, 1,0,1, 4'h1, 4'h1, 1,0, 5'd0, 0,0));
    tv.push_back(mk(0, 0,0,1, 4'h0, 4'hF, 1,0, 5'd0, 0,0));
    tv.push_back(mk(0, 0,0,1, 4'h0, 4'h8, 1,0, 5'd0, 0,0));
    tv.push_back(mk(0, 0,0,1, 4'h0, 4'h4, 1,0, 5'd0, 0,0));
    tv.push_back(mk(0, 0,0,1, 4'h0, 4'h2, 1,0, 5'd0, 0,0));
    tv.push_back(mk(0, 0,0,1, 4'h0, 4'h1, 0,1, 5'd5, 0,0));
    tv.push_back(mk(0, 0,0,1, 4'h0, 4'hF, 0,0, 5'd5, 0,0));
    tv.push_back(mk(0, 0,0,0, 4'h0, 4'hF, 0,0, 5'd5, 0,0));
    // zero seed replaced, seed_err one cycle
    tv.push_back(mk(0, 1,0,0, 4'h0, 4'h1, 1,0, 5'd5, 0,1));
    // measure restart with i_valid high: no advance
    tv.push_back(mk(0, 0,1,1, 4'h0, 4'h1, 1,0, 5'd5, 0,0));
    tv.push_back(mk(0, 0,0,1, 4'h0, 4'hF, 1,0, 5'd5, 0,0));
    tv.push_back(mk(0, 0,0,1, 4'h0, 4'h8, 1,0, 5'd5, 0,0));
    tv.push_back(mk(0, 0,0,1, 4'h0, 4'h4, 1,0, 5'd5, 0,0));
    tv.push_back(mk(0, 0,0,1, 4'h0, 4'h2, 1,0, 5'd5, 0,0));
    tv.push_back(mk(0, 0,0,1, 4'h0, 4'h1, 0,1, 5'd5, 0,0));
    // TAPS=3, seed 8: tail into 1/3/2 loop, timeout after 16 advances
    seq4b = '{4'h4, 4'h2, 4'h1, 4'h3, 4'h2, 4'h1, 4'h3, 4'h2,
              4'h1, 4'h3, 4'h2, 4'h1, 4'h3, 4'h2, 4'h1, 4'h3};
    tv.push_back(mk(1, 1,0,0, 4'h8, 4'h8, 1,0, 5'd0, 0,0));
    for (int i = 0; i < 16; i++)
      tv.push_back(mk(1, 0,0,1, 4'h0, seq4b[i], (i < 15), 0, 5'd0, (i == 15), 0));
    tv.push_back(mk(1, 0,0,1, 4'h0, 4'h2, 0,0, 5'd0, 1,0));
    tv.push_back(mk(1, 0,1,1, 4'h0, 4'h2, 1,0, 5'd0, 0,0));

    // ---- reset state ----
    #12;
    chk("rst_lfsr8", 32'(lf8), 32'h01);
    chk("rst_period8", 32'(per8), 0);
    chk("rst_busy8", 32'(bz8), 0);
    chk("rst_flags8", 32'({se8, pv8, to8}), 0);
    chk("rst_lfsr4a", 32'(a_lf), 32'h1);
    chk("rst_lfsr4b", 32'(b_lf), 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    // ---- table ----
    foreach (tv[i]) begin
      a_sr = (tv[i].sel == 0) ? tv[i].sr : 1'b0;
      a_ms = (tv[i].sel == 0) ? tv[i].ms : 1'b0;
      a_v  = (tv[i].sel == 0) ? tv[i].vl : 1'b0;
      a_seed = tv[i].seed;
      b_sr = (tv[i].sel == 1) ? tv[i].sr : 1'b0;
      b_ms = (tv[i].sel == 1) ? tv[i].ms : 1'b0;
      b_v  = (tv[i].sel == 1) ? tv[i].vl : 1'b0;
      b_seed = tv[i].seed;
      tick();
      if (tv[i].sel == 0) begin
        o_lf = a_lf; o_bz = a_bz; o_pv = a_pv; o_per = a_per; o_to = a_to; o_se = a_se;
      end else begin
        o_lf = b_lf; o_bz = b_bz; o_pv = b_pv; o_per = b_per; o_to = b_to; o_se = b_se;
      end
      chk($sformatf("tv%0d_lfsr", i), 32'(o_lf), 32'(tv[i].lf));
      chk($sformatf("tv%0d_busy", i), 32'(o_bz), 32'(tv[i].bz));
      chk($sformatf("tv%0d_pvalid", i), 32'(o_pv), 32'(tv[i].pv));
      chk($sformatf("tv%0d_period", i), 32'(o_per), 32'(tv[i].per));
      chk($sformatf("tv%0d_timeout", i), 32'(o_to), 32'(tv[i].to));
      chk($sformatf("tv%0d_seed_err", i), 32'(o_se), 32'(tv[i].se));
    end
    {a_v, a_sr, a_ms, b_v, b_sr, b_ms} = '0;

    // ---- 8-bit: seed 1, i_valid toggling -> pulse 510 clk after start ----
    sr8 = 1'b1; seed8 = 8'h01; v8 = 1'b0;
    tick();
    sr8 = 1'b0;
    chk("s1_start_lfsr", 32'(lf8), 32'h01);
    chk("s1_start_busy", 32'(bz8), 1);
    m = 8'h01; pv_at = -1; npv = 0; bad = 0; lf_at = '0; per_at = '0;
    for (int k = 1; k <= 520; k++) begin
      v8 = (k % 2 == 0);
      tick();
      if (v8) m = nxt8(m);
      if (lf8 !== m) bad++;
      if (pv8) begin
        npv++;
        if (pv_at < 0) begin pv_at = k; lf_at = lf8; per_at = per8; end
      end
    end
    v8 = 1'b0;
    chk("s1_pulse_time", 32'(pv_at), 32'd510);
    chk("s1_pulse_count", 32'(npv), 1);
    chk("s1_lfsr_at_pulse", 32'(lf_at), 32'h01);
    chk("s1_period", 32'(per_at), 32'd255);
    chk("s1_sequence_errs", 32'(bad), 0);
    chk("s1_done_busy", 32'(bz8), 0);
    chk("s1_timeout", 32'(to8), 0);

    // ---- zero seed ----
    sr8 = 1'b1; seed8 = 8'h00; v8 = 1'b1;
    tick();
    sr8 = 1'b0;
    chk("s2_lfsr", 32'(lf8), 32'h01);
    chk("s2_seed_err_hi", 32'(se8), 1);
    m = 8'h01; pv_at = -1; npv = 0; bad = 0;
    for (int k = 1; k <= 300; k++) begin
      tick();
      if (k == 1) chk("s2_seed_err_lo", 32'(se8), 0);
      m = nxt8(m);
      if (lf8 !== m) bad++;
      if (pv8) begin
        npv++;
        if (pv_at < 0) begin pv_at = k; per_at = per8; end
      end
    end
    v8 = 1'b0;
    chk("s2_pulse_adv", 32'(pv_at), 32'd255);
    chk("s2_period", 32'(per_at), 32'd255);
    chk("s2_sequence_errs", 32'(bad), 0);

    // ---- start with i_valid, then measure mid-run at cnt=40 ----
    sr8 = 1'b1; seed8 = 8'h01; v8 = 1'b1;
    tick();
    sr8 = 1'b0;
    chk("s5_no_adv_on_sr", 32'(lf8), 32'h01);
    m = 8'h01;
    for (int k = 0; k < 40; k++) begin
      tick();
      m = nxt8(m);
    end
    chk("s5_pre_capture", 32'(lf8), 32'(m));
    ms8 = 1'b1;
    tick();
    ms8 = 1'b0;
    cap = m;
    chk("s5_no_adv_on_ms", 32'(lf8), 32'(cap));
    chk("s5_busy", 32'(bz8), 1);
    pv_at = -1; npv = 0; lf_at = '0; per_at = '0;
    for (int k = 1; k <= 300; k++) begin
      tick();
      if (pv8) begin
        npv++;
        if (pv_at < 0) begin pv_at = k; lf_at = lf8; per_at = per8; end
      end
    end
    v8 = 1'b0;
    chk("s5_pulse_adv", 32'(pv_at), 32'd255);
    chk("s5_pulse_count", 32'(npv), 1);
    chk("s5_lfsr_at_pulse", 32'(lf_at), 32'(cap));
    chk("s5_period", 32'(per_at), 32'd255);

    // ---- async reset mid-MEASURE ----
    sr8 = 1'b1; seed8 = 8'h5A; v8 = 1'b1;
    tick();
    sr8 = 1'b0;
    for (int k = 0; k < 10; k++) tick();
    chk("s6_busy_before", 32'(bz8), 1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("s6_lfsr", 32'(lf8), 32'h01);
    chk("s6_busy", 32'(bz8), 0);
    chk("s6_period", 32'(per8), 0);
    chk("s6_timeout", 32'(to8), 0);
    chk("s6_pvalid", 32'(pv8), 0);
    v8 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("s6_idle_after", 32'(bz8), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
